// File: rtl/seq_detect_param_pkg.sv
// Shared defaults and helpers for the programmable serial sequence detector.
// The reset configuration reproduces the legacy overlapping "101" detector.
package seq_detect_param_pkg;

    localparam logic [31:0] DEF_PATTERN = 32'b101;
    localparam int          DEF_LEN     = 3;
    localparam logic        DEF_OVERLAP = 1'b1;

    typedef enum logic [1:0] {
        FILL_EMPTY,
        FILL_FILLING,
        FILL_ARMED
    } fill_state_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module seq_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial bit-sequence detector with valid qualifier,
// overlap control, saturating match counter and optional registered output.
module seq_detect_param
    import seq_detect_param_pkg::*;
#(
    parameter int MAX_LEN        = 8,
    parameter int CNT_W          = 8,
    parameter bit REGISTERED_OUT = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in,
    input  logic                       cfg_load,
    input  logic [MAX_LEN-1:0]         cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]  cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       count_clear,
    output logic                       out,
    output logic [CNT_W-1:0]           match_count,
    output logic                       cfg_ok
);

    localparam int                 LEN_W     = len_w(MAX_LEN);
    localparam logic [MAX_LEN-1:0] L_DEF_PAT = MAX_LEN'(DEF_PATTERN);
    localparam logic [LEN_W-1:0]   L_DEF_LEN = LEN_W'(DEF_LEN);
    localparam logic [LEN_W-1:0]   L_MAX_LEN = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_cfg_ok;
    // Only MAX_LEN-1 history bits are kept: the live input bit completes the window.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;

    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_bit_ok;
    logic               w_eq;
    logic               w_accept;
    logic               w_cfg_len_ok;
    logic               w_last_fill;
    logic               w_fill_ok;
    logic               w_match;
    logic [LEN_W-1:0]   w_fill_inc;
    fill_state_e        w_state;

    assign w_accept     = in_valid & ~cfg_load;
    assign w_window     = {r_hist, in};
    assign w_cfg_len_ok = (cfg_len >= LEN_W'(2)) && (cfg_len <= L_MAX_LEN);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
            assign w_bit_ok[gi] = (LEN_W'(gi) >= r_len) || (w_window[gi] == r_pattern[gi]);
        end
    endgenerate

    assign w_eq = &w_bit_ok;

    always_comb begin
        w_state = FILL_EMPTY;
        if (r_fill != '0) begin
            w_state = (r_fill < r_len) ? FILL_FILLING : FILL_ARMED;
        end
    end

    // The incoming bit counts toward the window, so one short of len is enough.
    assign w_last_fill = (({1'b0, r_fill} + (LEN_W+1)'(1)) == {1'b0, r_len});
    assign w_fill_ok   = (w_state == FILL_ARMED) || w_last_fill;
    assign w_match     = w_accept & r_cfg_ok & w_fill_ok & w_eq;
    assign w_fill_inc  = (r_fill == L_MAX_LEN) ? r_fill : r_fill + LEN_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern <= L_DEF_PAT;
            r_len     <= L_DEF_LEN;
            r_overlap <= DEF_OVERLAP;
            r_cfg_ok  <= 1'b1;
            r_hist    <= '0;
            r_fill    <= '0;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
            r_cfg_ok  <= w_cfg_len_ok;
            r_hist    <= '0;
            r_fill    <= '0;
        end else if (w_accept) begin
            r_hist <= w_window[MAX_LEN-2:0];
            r_fill <= (w_match && !r_overlap) ? '0 : w_fill_inc;
        end
    end

    generate
        if (REGISTERED_OUT) begin : g_reg_out
            logic r_out;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_out <= 1'b0;
                end else begin
                    r_out <= w_match;
                end
            end
            assign out = r_out;
        end else begin : g_comb_out
            assign out = w_match;
        end
    endgenerate

    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_inc   (w_match),
        .i_clr   (count_clear),
        .o_count (match_count)
    );

    assign cfg_ok = r_cfg_ok;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (Mealy/8-bit count, registered out,
// 2-bit count) share one directed stimulus; a monitor scores every cycle.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'b101;
    logic [3:0] cfg_len = 4'd3;
    logic       cfg_overlap = 1'b1;
    logic       count_clear = 1'b0;

    logic       out0, out1, out2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic       ok0, ok1, ok2;

    always #5 clk = ~clk;

    seq_detect_param #(.MAX_LEN(8), .CNT_W(8), .REGISTERED_OUT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .count_clear(count_clear), .out(out0), .match_count(cnt0), .cfg_ok(ok0));

    seq_detect_param #(.MAX_LEN(8), .CNT_W(8), .REGISTERED_OUT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .count_clear(count_clear), .out(out1), .match_count(cnt1), .cfg_ok(ok1));

    seq_detect_param #(.MAX_LEN(8), .CNT_W(2), .REGISTERED_OUT(1'b0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .count_clear(count_clear), .out(out2), .match_count(cnt2), .cfg_ok(ok2));

    typedef struct {
        bit exp;
        bit rst;
        bit clr;
    } item_t;

    item_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit v, input bit b, input bit exp, input bit ld = 1'b0, input bit clr = 1'b0);
        @(posedge clk);
        #1;
        in_valid    = v;
        in          = b;
        cfg_load    = ld;
        count_clear = clr;
        q.push_back(item_t'{exp, 1'b0, clr});
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic stream(input string bits, input string exps);
        for (int i = 0; i < bits.len(); i++) begin
            cyc(1'b1, bits[i] == "1", exps[i] == "1");
        end
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit ov);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
    endtask

    // Reset lands mid-stream with a live bit on the input; nothing may match.
    task automatic rst_pulse();
        @(posedge clk);
        #1;
        reset       = 1'b0;
        in_valid    = 1'b1;
        in          = 1'b1;
        cfg_load    = 1'b0;
        count_clear = 1'b0;
        q.push_back(item_t'{1'b0, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        q.push_back(item_t'{1'b0, 1'b0, 1'b0});
    endtask

    initial begin : monitor
        item_t it;
        bit    prev1;
        int    m0;
        int    m2;
        prev1 = 1'b0;
        m0    = 0;
        m2    = 0;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                it = q.pop_front();
                if (it.rst) begin
                    m0    = 0;
                    m2    = 0;
                    prev1 = 1'b0;
                end
                check("mealy_out", 32'(out0), 32'(it.exp));
                check("mealy_out_cnt2", 32'(out2), 32'(it.exp));
                check("reg_out", 32'(out1), 32'(prev1));
                check("count", 32'(cnt0), 32'(m0));
                check("count_regout", 32'(cnt1), 32'(m0));
                check("count_sat", 32'(cnt2), 32'(m2));
                prev1 = it.exp;
                if (it.clr) begin
                    m0 = 0;
                    m2 = 0;
                end else if (it.exp) begin
                    if (m0 < 255) m0++;
                    if (m2 < 3) m2++;
                end
            end
        end
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        #1;
        check("rst_out0", 32'(out0), 0);
        check("rst_out1", 32'(out1), 0);
        check("rst_cnt0", 32'(cnt0), 0);
        check("rst_cnt2", 32'(cnt2), 0);
        check("rst_cfg_ok", 32'(ok0), 1);
        check("rst_cfg_ok_reg", 32'(ok1), 1);
        reset = 1'b1;

        // Legacy 101 detector, overlapping.
        stream("10101", "00101");
        idle();
        check("s1_cnt", 32'(cnt0), 2);
        check("s1_cnt2", 32'(cnt2), 2);

        // Gaps in in_valid between bits.
        rst_pulse();
        cyc(1'b1, 1'b1, 1'b0);
        repeat (3) idle();
        stream("01", "01");
        idle();
        check("s4_cnt", 32'(cnt0), 1);

        // 1111 with and without overlap.
        load(8'b0000_1111, 4'd4, 1'b1);
        stream("111111", "000111");
        load(8'b0000_1111, 4'd4, 1'b0);
        stream("111111", "000100");
        idle();
        check("s3_cnt", 32'(cnt0), 5);
        check("s3_cnt2_sat", 32'(cnt2), 3);

        // Full-length pattern, no overlap; the 11 suffix/prefix overlap must not re-fire.
        load(8'b1101_0011, 4'd8, 1'b0);
        stream("1101001111010011", "0000000100000001");
        stream("010011", "000000");
        idle();
        check("s2_cnt", 32'(cnt0), 7);

        // Clear coincident with a match, then saturation of the 2-bit counter.
        rst_pulse();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        check("s5_clr_cnt", 32'(cnt0), 0);
        rst_pulse();
        stream("10101010101", "00101010101");
        idle();
        check("s5_cnt", 32'(cnt0), 5);
        check("s5_cnt2_sat", 32'(cnt2), 3);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        check("s5_clr_cnt0", 32'(cnt0), 0);
        check("s5_clr_cnt2", 32'(cnt2), 0);

        // Illegal lengths, mid-pattern load, mid-stream reset.
        load(8'b101, 4'd0, 1'b1);
        check("s6_len0_ok", 32'(ok0), 0);
        stream("10101", "00000");
        load(8'b101, 4'd9, 1'b1);
        check("s6_len9_ok", 32'(ok0), 0);
        stream("101101", "000000");
        load(8'b101, 4'd3, 1'b1);
        check("s6_len3_ok", 32'(ok0), 1);
        stream("10", "00");
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        stream("0101", "0001");
        stream("10", "00");
        rst_pulse();
        stream("0101", "0001");
        idle();
        idle();

        repeat (3) @(posedge clk);
        if (q.size() != 0) check("drain", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
